// File: rtl/rtlola_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : rtlola_event_scheduler
//  Purpose  : Front-end controller for the generated monitor. Merges input
//             events and periodic deadlines into one timestamped FIFO and
//             hands entries to the evaluator one at a time
//             (IDLE -> ISSUE -> BUSY, released by eval_done).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    rst          in   asynchronous reset, active-low
//    en           in   global enable; 0 freezes all state, strobes forced 0
//    in_data      in   packed input values, stream i at [i*DATA_W +: DATA_W]
//    in_new       in   per-stream new-value strobe
//    eval_done    in   evaluator finished the current entry (used in BUSY)
//    ev_data      out  values of issued entry (non-new streams are 0)
//    ev_ts        out  timestamp of issued entry
//    pacing_in    out  per-stream pacing of issued entry (ev_valid cycle)
//    pacing_per   out  issued entry carries a periodic deadline
//    ev_valid     out  1-cycle issue strobe
//    q_push       out  an entry was formed this cycle
//    q_push_valid out  the formed entry was accepted into the queue
//    q_pop        out  FSM was ready to pop (IDLE)
//    q_pop_valid  out  an entry was actually popped
//    overflow     out  sticky: an entry was dropped on a full queue
//    drop_cnt     out  (SCHED_DROP_COUNT_EN only) saturating drop counter
//  Configuration macro: SCHED_DROP_COUNT_EN
// ============================================================================
module rtlola_event_scheduler #(
    parameter int NUM_INPUTS    = 2,
    parameter int DATA_W        = 64,
    parameter int TS_W          = 32,
    parameter int PERIOD_CYCLES = 500,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]        in_new,
    input  logic                         eval_done,
    output logic [NUM_INPUTS*DATA_W-1:0] ev_data,
    output logic [TS_W-1:0]              ev_ts,
    output logic [NUM_INPUTS-1:0]        pacing_in,
    output logic                         pacing_per,
    output logic                         ev_valid,
    output logic                         q_push,
    output logic                         q_push_valid,
    output logic                         q_pop,
    output logic                         q_pop_valid,
    output logic                         overflow
`ifdef SCHED_DROP_COUNT_EN
    ,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int c_AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int c_DW = NUM_INPUTS * DATA_W;

    localparam logic [c_PW-1:0] c_PERIOD_LAST = c_PW'(PERIOD_CYCLES - 1);
    localparam logic [c_PW-1:0] c_PC_ONE      = c_PW'(1);
    localparam logic [c_AW:0]   c_DEPTH       = (c_AW + 1)'(QUEUE_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE     = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE     = c_AW'(1);
    localparam logic [TS_W-1:0] c_TS_ONE      = TS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t r_state;

    logic [TS_W-1:0]       r_ts;
    logic [c_PW-1:0]       r_period_cnt;

    // FIFO storage and bookkeeping
    logic [TS_W-1:0]       r_q_ts   [QUEUE_DEPTH];
    logic [NUM_INPUTS-1:0] r_q_new  [QUEUE_DEPTH];
    logic [c_DW-1:0]       r_q_data [QUEUE_DEPTH];
    logic                  r_q_per  [QUEUE_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;

    // Entry popped in IDLE, presented on the outputs in ISSUE
    logic [TS_W-1:0]       r_hold_ts;
    logic [NUM_INPUTS-1:0] r_hold_new;
    logic [c_DW-1:0]       r_hold_data;
    logic                  r_hold_per;

    logic [c_DW-1:0]       r_ev_data;
    logic [TS_W-1:0]       r_ev_ts;
    logic [NUM_INPUTS-1:0] r_pacing_in;
    logic                  r_pacing_per;
    logic                  r_ev_valid;
    logic                  r_q_push;
    logic                  r_q_push_valid;
    logic                  r_q_pop;
    logic                  r_q_pop_valid;
    logic                  r_overflow;

    logic [c_DW-1:0]       w_masked;
    logic                  w_tick;
    logic                  w_form;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // Streams without a new value contribute zeros to the entry
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_mask
        assign w_masked[gi*DATA_W +: DATA_W] =
            in_new[gi] ? in_data[gi*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    end

    assign w_tick = (r_period_cnt == c_PERIOD_LAST);
    // An event and a deadline in the same cycle form a single entry
    assign w_form = en & ((|in_new) | w_tick);
    assign w_full = (r_count == c_DEPTH);
    // Pop decision uses the pre-push occupancy, so a push into an empty
    // queue is only visible to the FSM on the following cycle
    assign w_pop  = en & (r_state == S_IDLE) & (r_count != '0);
    // A full queue still accepts when the head leaves in the same cycle
    assign w_push = w_form & (~w_full | w_pop);
    assign w_drop = w_form & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ts[r_wr_ptr]   <= r_ts;
            r_q_new[r_wr_ptr]  <= in_new;
            r_q_data[r_wr_ptr] <= w_masked;
            r_q_per[r_wr_ptr]  <= w_tick;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_ts           <= '0;
            r_period_cnt   <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_hold_ts      <= '0;
            r_hold_new     <= '0;
            r_hold_data    <= '0;
            r_hold_per     <= 1'b0;
            r_ev_data      <= '0;
            r_ev_ts        <= '0;
            r_pacing_in    <= '0;
            r_pacing_per   <= 1'b0;
            r_ev_valid     <= 1'b0;
            r_q_push       <= 1'b0;
            r_q_push_valid <= 1'b0;
            r_q_pop        <= 1'b0;
            r_q_pop_valid  <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (!en) begin
            r_pacing_in    <= '0;
            r_pacing_per   <= 1'b0;
            r_ev_valid     <= 1'b0;
            r_q_push       <= 1'b0;
            r_q_push_valid <= 1'b0;
            r_q_pop        <= 1'b0;
            r_q_pop_valid  <= 1'b0;
        end else begin
            r_ts           <= r_ts + c_TS_ONE;
            r_period_cnt   <= w_tick ? '0 : r_period_cnt + c_PC_ONE;
            r_q_push       <= w_form;
            r_q_push_valid <= w_push;
            r_q_pop        <= (r_state == S_IDLE);
            r_q_pop_valid  <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_ev_valid   <= 1'b0;
            r_pacing_in  <= '0;
            r_pacing_per <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold_ts   <= r_q_ts[r_rd_ptr];
                        r_hold_new  <= r_q_new[r_rd_ptr];
                        r_hold_data <= r_q_data[r_rd_ptr];
                        r_hold_per  <= r_q_per[r_rd_ptr];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ev_valid   <= 1'b1;
                    r_ev_data    <= r_hold_data;
                    r_ev_ts      <= r_hold_ts;
                    r_pacing_in  <= r_hold_new;
                    r_pacing_per <= r_hold_per;
                    r_state      <= S_BUSY;
                end
                S_BUSY: begin
                    // ev_data/ev_ts stay on the outputs until the evaluator is done
                    if (eval_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SCHED_DROP_COUNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign ev_data      = r_ev_data;
    assign ev_ts        = r_ev_ts;
    assign pacing_in    = r_pacing_in;
    assign pacing_per   = r_pacing_per;
    assign ev_valid     = r_ev_valid;
    assign q_push       = r_q_push;
    assign q_push_valid = r_q_push_valid;
    assign q_pop        = r_q_pop;
    assign q_pop_valid  = r_q_pop_valid;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rtlola_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtlola_event_scheduler
//  Purpose  : Self-checking bench for rtlola_event_scheduler. A queue-based
//             reference model predicts every output each cycle; directed
//             scenarios pin issued entries to hand-computed values, then a
//             long randomized run follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtlola_event_scheduler;

    localparam int P  = 8;
    localparam int D  = 4;
    localparam int NI = 2;
    localparam int DW = 64;
    localparam int TW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NI*DW-1:0] in_data;
    logic [NI-1:0]   in_new;
    logic            eval_done;
    logic [NI*DW-1:0] ev_data;
    logic [TW-1:0]   ev_ts;
    logic [NI-1:0]   pacing_in;
    logic            pacing_per;
    logic            ev_valid;
    logic            q_push;
    logic            q_push_valid;
    logic            q_pop;
    logic            q_pop_valid;
    logic            overflow;
`ifdef SCHED_DROP_COUNT_EN
    logic [15:0]     drop_cnt;
`endif

    rtlola_event_scheduler #(
        .NUM_INPUTS(NI), .DATA_W(DW), .TS_W(TW),
        .PERIOD_CYCLES(P), .QUEUE_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_new(in_new),
        .eval_done(eval_done), .ev_data(ev_data), .ev_ts(ev_ts),
        .pacing_in(pacing_in), .pacing_per(pacing_per), .ev_valid(ev_valid),
        .q_push(q_push), .q_push_valid(q_push_valid), .q_pop(q_pop),
        .q_pop_valid(q_pop_valid), .overflow(overflow)
`ifdef SCHED_DROP_COUNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0]    ts;
        logic [NI-1:0]    nw;
        logic [NI*DW-1:0] data;
        logic             per;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    ent_t          mq[$];
    ent_t          m_hold;
    logic [TW-1:0] m_ts;
    int            m_pc;
    int            m_phase;   // 0 waiting for work, 1 about to issue, 2 evaluator busy
    int            m_drops;
    logic [NI*DW-1:0] e_ev_data;
    logic [TW-1:0] e_ev_ts;
    logic [NI-1:0] e_pin;
    logic          e_pper, e_evv, e_qp, e_qpv, e_qo, e_qov, e_ovf;

    // observation / responder state
    ent_t seen[$];
    int   n_push, n_pushv;
    int   cd  = -1;
    int   dly = 0;
    bit   spur_en = 1'b0;

    function automatic void chk(string name, logic [NI*DW-1:0] got, logic [NI*DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_hold = '0; m_ts = '0; m_pc = 0; m_phase = 0; m_drops = 0;
        e_ev_data = '0; e_ev_ts = '0; e_pin = '0; e_pper = 1'b0; e_evv = 1'b0;
        e_qp = 1'b0; e_qpv = 1'b0; e_qo = 1'b0; e_qov = 1'b0; e_ovf = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs the DUT sampled
    function automatic void model_step();
        ent_t e;
        bit tick, formed, do_pop, accept;
        if (!en) begin
            e_qp = 0; e_qpv = 0; e_qo = 0; e_qov = 0; e_evv = 0; e_pin = '0; e_pper = 0;
            return;
        end
        tick   = (m_pc == P - 1);
        formed = (in_new != '0) || tick;
        do_pop = (m_phase == 0) && (mq.size() > 0);
        accept = (mq.size() < D) || do_pop;
        e_qo = (m_phase == 0); e_qov = do_pop;
        e_evv = 0; e_pin = '0; e_pper = 0;
        case (m_phase)
            0: if (do_pop) begin m_hold = mq.pop_front(); m_phase = 1; end
            1: begin
                e_evv = 1; e_ev_ts = m_hold.ts; e_ev_data = m_hold.data;
                e_pin = m_hold.nw; e_pper = m_hold.per; m_phase = 2;
            end
            default: if (eval_done) m_phase = 0;
        endcase
        e_qp  = formed;
        e_qpv = formed && accept;
        if (formed) begin
            if (accept) begin
                e.ts = m_ts; e.nw = in_new; e.per = tick;
                for (int i = 0; i < NI; i++)
                    e.data[i*DW +: DW] = in_new[i] ? in_data[i*DW +: DW] : '0;
                mq.push_back(e);
            end else begin
                e_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        m_ts = m_ts + 1;
        m_pc = tick ? 0 : m_pc + 1;
    endfunction

    function automatic void compare_all();
        chk("ev_data", ev_data, e_ev_data);
        chk("ev_ts", {96'd0, ev_ts}, {96'd0, e_ev_ts});
        chk("pacing_in", {126'd0, pacing_in}, {126'd0, e_pin});
        chk("pacing_per", {127'd0, pacing_per}, {127'd0, e_pper});
        chk("ev_valid", {127'd0, ev_valid}, {127'd0, e_evv});
        chk("q_push", {127'd0, q_push}, {127'd0, e_qp});
        chk("q_push_valid", {127'd0, q_push_valid}, {127'd0, e_qpv});
        chk("q_pop", {127'd0, q_pop}, {127'd0, e_qo});
        chk("q_pop_valid", {127'd0, q_pop_valid}, {127'd0, e_qov});
        chk("overflow", {127'd0, overflow}, {127'd0, e_ovf});
`ifdef SCHED_DROP_COUNT_EN
        chk("drop_cnt", {112'd0, drop_cnt}, {112'd0, 16'(m_drops)});
`endif
    endfunction

    // Log issues, count pushes, and drive eval_done for the next cycle
    function automatic void observe();
        ent_t s;
        if (ev_valid) begin
            s.ts = ev_ts; s.nw = pacing_in; s.data = ev_data; s.per = pacing_per;
            seen.push_back(s);
            cd = dly;
        end
        if (q_push) n_push++;
        if (q_push_valid) n_pushv++;
        if (cd == 0) begin
            eval_done = 1'b1; cd = -1;
        end else begin
            eval_done = (cd < 0 && spur_en) ? ($urandom_range(7) == 0) : 1'b0;
            if (cd > 0) cd--;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare_all();
        observe();
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b1; in_new = '0; in_data = '0; eval_done = 1'b0;
        cd = -1; model_reset();
        repeat (2) cycle();
        rst = 1'b1;
        seen.delete(); n_push = 0; n_pushv = 0;
    endtask

    // Reset asserted between edges: outputs must clear before the next clock
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        eval_done = 1'b0; cd = -1; in_new = '0;
        repeat (2) cycle();
        rst = 1'b1;
        seen.delete(); n_push = 0; n_pushv = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; in_new = '0; in_data = '0; eval_done = 1'b0;
        model_reset();

        // reset state
        do_reset();
        chk("reset_ev_valid", {127'd0, ev_valid}, 128'd0);
        chk("reset_overflow", {127'd0, overflow}, 128'd0);

        // event at ts=3, periodic deadlines at 7, 15, 23
        dly = 2;
        repeat (3) cycle();
        in_new = 2'b11; in_data = {64'd2, 64'd1};
        cycle();
        in_new = '0;
        repeat (24) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
        end
        chk("s1_issues", 128'(seen.size()), 128'd4);
        if (seen.size() >= 4) begin
            chk("s1_ts", {96'd0, seen[0].ts}, 128'd3);
            chk("s1_pin", {126'd0, seen[0].nw}, 128'd3);
            chk("s1_per", {127'd0, seen[0].per}, 128'd0);
            chk("s1_data", seen[0].data, {64'd2, 64'd1});
            chk("s2_ts7", {96'd0, seen[1].ts}, 128'd7);
            chk("s2_per7", {127'd0, seen[1].per}, 128'd1);
            chk("s2_pin7", {126'd0, seen[1].nw}, 128'd0);
            chk("s2_data7", seen[1].data, 128'd0);
            chk("s2_ts15", {96'd0, seen[2].ts}, 128'd15);
            chk("s2_ts23", {96'd0, seen[3].ts}, 128'd23);
        end

        // event coincident with tick at ts=7, then overflow with evaluator held
        do_reset();
        dly = 1000;
        repeat (7) cycle();
        in_new = 2'b01; in_data = {64'h5555, 64'hABCD};
        cycle();
        n_push = 0; n_pushv = 0;
        repeat (6) begin
            in_new = 2'($urandom_range(3, 1));
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
        end
        in_new = '0;
        chk("s4_push", 128'(n_push), 128'd6);
        chk("s4_push_valid", 128'(n_pushv), 128'd4);
        chk("s4_overflow", {127'd0, overflow}, 128'd1);
`ifdef SCHED_DROP_COUNT_EN
        chk("s4_drop_cnt", {112'd0, drop_cnt}, 128'd2);
`endif
        dly = 1; cd = -1; eval_done = 1'b1;
        repeat (20) cycle();
        chk("s4_issues", 128'(seen.size()), 128'd6);
        if (seen.size() >= 6) begin
            chk("s3_pin", {126'd0, seen[0].nw}, 128'd1);
            chk("s3_per", {127'd0, seen[0].per}, 128'd1);
            chk("s3_data", seen[0].data, 128'hABCD);
            chk("s4_ts0", {96'd0, seen[0].ts}, 128'd7);
            chk("s4_ts1", {96'd0, seen[1].ts}, 128'd8);
            chk("s4_ts2", {96'd0, seen[2].ts}, 128'd9);
            chk("s4_ts3", {96'd0, seen[3].ts}, 128'd10);
            chk("s4_ts4", {96'd0, seen[4].ts}, 128'd11);
            chk("s4_ts5", {96'd0, seen[5].ts}, 128'd15);
        end

        // asynchronous reset while busy with three entries queued
        do_reset();
        dly = 1000;
        cycle();
        repeat (4) begin in_new = 2'b10; in_data = {$urandom(), $urandom(), $urandom(), $urandom()}; cycle(); end
        in_new = '0;
        cycle();
        async_reset();
        chk("s5_ev_ts", {96'd0, ev_ts}, 128'd0);
        chk("s5_strobes", {122'd0, ev_valid, q_push, q_push_valid, q_pop, q_pop_valid, overflow}, 128'd0);
        dly = 0;
        repeat (12) cycle();
        chk("s5_issues", 128'(seen.size()), 128'd1);
        if (seen.size() >= 1) begin
            chk("s5_ts", {96'd0, seen[0].ts}, 128'd7);
            chk("s5_per", {127'd0, seen[0].per}, 128'd1);
        end

        // enable dropped for 10 cycles mid-period
        do_reset();
        dly = 0;
        repeat (3) cycle();
        en = 1'b0; n_push = 0;
        repeat (10) begin in_new = 2'($urandom()); cycle(); end
        chk("s6_no_push", 128'(n_push), 128'd0);
        en = 1'b1; in_new = '0;
        repeat (8) cycle();
        chk("s6_issues", 128'(seen.size()), 128'd1);
        if (seen.size() >= 1)
            chk("s6_ts", {96'd0, seen[0].ts}, 128'd7);

        // randomized run
        do_reset();
        spur_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(49) == 0) dly = $urandom_range(3);
            en = ($urandom_range(9) != 0);
            in_new = ($urandom_range(3) == 0) ? 2'($urandom()) : 2'b00;
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
            if ($urandom_range(699) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
